// File: rtl/awb_gain_pkg.sv
// Shared constants, FSM state type and arithmetic helpers for the
// gray-world auto-white-balance block.
package awb_gain_pkg;

    localparam int DATA_W    = 8;
    localparam int GAIN_FRAC = 6;
    localparam int GAIN_W    = 10;
    localparam int DVD_W     = DATA_W + GAIN_FRAC;      // divider dividend / quotient width
    localparam int PROD_W    = DATA_W + GAIN_W;         // pixel * gain product width
    localparam int SH_W      = PROD_W - GAIN_FRAC;      // product after dropping fraction bits

    localparam logic [GAIN_W-1:0] UNITY_GAIN = GAIN_W'(1 << GAIN_FRAC);
    localparam logic [GAIN_W-1:0] GAIN_MAX   = '1;

    localparam logic [1:0] RED   = 2'd0;
    localparam logic [1:0] GREEN = 2'd1;
    localparam logic [1:0] BLUE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DIV_R = 2'd1,
        S_DIV_B = 2'd2,
        S_LOAD  = 2'd3
    } awb_state_t;

    // Clamp a raw quotient into the Q4.6 gain range; a zero divisor maps to the maximum.
    function automatic logic [GAIN_W-1:0] sat_gain(input logic [DVD_W-1:0] quo,
                                                   input logic             div_zero);
        if (div_zero || (quo > DVD_W'(GAIN_MAX)))
            return GAIN_MAX;
        else
            return quo[GAIN_W-1:0];
    endfunction

    // Multiply a pixel by a Q4.6 gain, truncate the fraction and saturate to 8 bits.
    function automatic logic [DATA_W-1:0] apply_gain(input logic [DATA_W-1:0] value,
                                                     input logic [GAIN_W-1:0] gain);
        logic [PROD_W-1:0] prod;
        logic [SH_W-1:0]   shifted;
        prod    = PROD_W'(value) * PROD_W'(gain);
        shifted = SH_W'(prod >> GAIN_FRAC);
        if (|shifted[SH_W-1:DATA_W])
            return '1;
        else
            return shifted[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/awb_gain_if.sv
// Signal bundle between the white-balance block and its neighbours:
// frame means in, pixel stream in and out, gain status out.
interface awb_gain_if;
    import awb_gain_pkg::*;

    logic              mean_valid_i;
    logic [DATA_W-1:0] r_mean_i;
    logic [DATA_W-1:0] g_mean_i;
    logic [DATA_W-1:0] b_mean_i;
    logic              valid_i;
    logic [1:0]        color_i;
    logic [DATA_W-1:0] value_i;
    logic              valid_o;
    logic [1:0]        color_o;
    logic [DATA_W-1:0] value_o;
    logic [GAIN_W-1:0] gain_r_o;
    logic [GAIN_W-1:0] gain_b_o;
    logic              gain_ready_o;
    logic              busy_o;

    // The white-balance block itself
    modport slave (
        input  mean_valid_i, r_mean_i, g_mean_i, b_mean_i,
        input  valid_i, color_i, value_i,
        output valid_o, color_o, value_o,
        output gain_r_o, gain_b_o, gain_ready_o, busy_o
    );

    // Whoever drives means and pixels and consumes the corrected stream
    modport master (
        output mean_valid_i, r_mean_i, g_mean_i, b_mean_i,
        output valid_i, color_i, value_i,
        input  valid_o, color_o, value_o,
        input  gain_r_o, gain_b_o, gain_ready_o, busy_o
    );
endinterface

// File: rtl/awb_gain_serial_div.sv
// Restoring serial divider, one quotient bit per clock, fixed DVD_W-cycle run.
// The saturated gain lands in o_quot on the final iteration edge and o_done
// pulses the following cycle. A new start may coincide with the final
// iteration of the previous run; the finished result is still captured.
module serial_div
    import awb_gain_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [DVD_W-1:0]  i_dividend,
    input  logic [DATA_W-1:0] i_divisor,
    output logic              o_last,
    output logic              o_done,
    output logic [GAIN_W-1:0] o_quot
);
    localparam int CNT_W = $clog2(DVD_W);

    logic              r_busy;
    logic [CNT_W-1:0]  r_cnt;
    logic [DVD_W-1:0]  r_dvd;
    logic [DATA_W-1:0] r_dvs;
    logic [DATA_W-1:0] r_rem;
    logic [DVD_W-1:0]  r_quo;
    logic              r_done;
    logic [GAIN_W-1:0] r_quot;

    logic [DATA_W:0]   w_trial;
    logic              w_fits;
    logic [DATA_W-1:0] w_rem_next;
    logic [DVD_W-1:0]  w_quo_next;

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    always_comb begin
        w_trial    = {r_rem, r_dvd[DVD_W-1]};
        w_fits     = (w_trial >= {1'b0, r_dvs});
        w_rem_next = w_fits ? DATA_W'(w_trial - {1'b0, r_dvs}) : DATA_W'(w_trial);
        w_quo_next = {r_quo[DVD_W-2:0], w_fits};
    end

    assign o_last = r_busy && (r_cnt == CNT_W'(DVD_W - 1));
    assign o_done = r_done;
    assign o_quot = r_quot;

    // Iteration state; a start overrides the working registers but not the finished result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_dvd  <= '0;
            r_dvs  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_done <= 1'b0;
            r_quot <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_busy) begin
                r_dvd <= {r_dvd[DVD_W-2:0], 1'b0};
                r_rem <= w_rem_next;
                r_quo <= w_quo_next;
                if (o_last) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_quot <= sat_gain(w_quo_next, (r_dvs == '0));
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (i_start) begin
                r_busy <= 1'b1;
                r_cnt  <= '0;
                r_dvd  <= i_dividend;
                r_dvs  <= i_divisor;
                r_rem  <= '0;
                r_quo  <= '0;
            end
        end
    end

endmodule

// File: rtl/awb_gain.sv
// Gray-world auto white balance: latches frame means, derives red and blue
// gains against green with a shared serial divider, and applies the active
// gains to the pixel stream with a single register stage.
module awb_gain
    import awb_gain_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    awb_gain_if.slave  bus
);
    awb_state_t        r_state;
    awb_state_t        w_state_next;

    logic [DATA_W-1:0] r_g_mean;
    logic [DATA_W-1:0] r_b_mean;
    logic [GAIN_W-1:0] r_gain_r;
    logic [GAIN_W-1:0] r_gain_b;
    logic [GAIN_W-1:0] r_gain_r_pend;
    logic              r_gain_ready;

    logic              r_valid;
    logic [1:0]        r_color;
    logic [DATA_W-1:0] r_value;
    logic [DATA_W-1:0] w_pix_value;

    logic              w_div_start;
    logic [DVD_W-1:0]  w_dividend;
    logic [DATA_W-1:0] w_divisor;
    logic              w_div_last;
    logic              w_div_done;
    logic [GAIN_W-1:0] w_div_quot;

    serial_div u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_dividend (w_dividend),
        .i_divisor  (w_divisor),
        .o_last     (w_div_last),
        .o_done     (w_div_done),
        .o_quot     (w_div_quot)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next state and divider launches. The red division starts straight from the
    // input means so both divisions fit back to back with no setup cycle.
    always_comb begin
        w_state_next = r_state;
        w_div_start  = 1'b0;
        w_dividend   = '0;
        w_divisor    = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.mean_valid_i) begin
                    w_state_next = S_DIV_R;
                    w_div_start  = 1'b1;
                    w_dividend   = {bus.g_mean_i, {GAIN_FRAC{1'b0}}};
                    w_divisor    = bus.r_mean_i;
                end
            end
            S_DIV_R: begin
                if (w_div_last) begin
                    w_state_next = S_DIV_B;
                    w_div_start  = 1'b1;
                    w_dividend   = {r_g_mean, {GAIN_FRAC{1'b0}}};
                    w_divisor    = r_b_mean;
                end
            end
            S_DIV_B: begin
                if (w_div_last) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Keep green and blue means for the second division; means arriving while busy are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_g_mean <= '0;
            r_b_mean <= '0;
        end else if ((r_state == S_IDLE) && bus.mean_valid_i) begin
            r_g_mean <= bus.g_mean_i;
            r_b_mean <= bus.b_mean_i;
        end
    end

    // Park the red result until blue is ready so both gains switch on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gain_r_pend <= UNITY_GAIN;
            r_gain_r      <= UNITY_GAIN;
            r_gain_b      <= UNITY_GAIN;
            r_gain_ready  <= 1'b0;
        end else begin
            r_gain_ready <= 1'b0;
            if ((r_state == S_DIV_B) && w_div_done)
                r_gain_r_pend <= w_div_quot;
            if (r_state == S_LOAD) begin
                r_gain_r     <= r_gain_r_pend;
                r_gain_b     <= w_div_quot;
                r_gain_ready <= 1'b1;
            end
        end
    end

    // Per-pixel gain selection; green and the reserved code pass through.
    always_comb begin
        w_pix_value = bus.value_i;
        case (bus.color_i)
            RED:     w_pix_value = apply_gain(bus.value_i, r_gain_r);
            BLUE:    w_pix_value = apply_gain(bus.value_i, r_gain_b);
            default: w_pix_value = bus.value_i;
        endcase
    end

    // Pixel output stage, always running regardless of the gain FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_color <= '0;
            r_value <= '0;
        end else begin
            r_valid <= bus.valid_i;
            r_color <= bus.color_i;
            r_value <= w_pix_value;
        end
    end

    assign bus.valid_o      = r_valid;
    assign bus.color_o      = r_color;
    assign bus.value_o      = r_value;
    assign bus.gain_r_o     = r_gain_r;
    assign bus.gain_b_o     = r_gain_b;
    assign bus.gain_ready_o = r_gain_ready;
    assign bus.busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_awb_gain.sv
// Scoreboard bench for awb_gain: drivers queue hand-computed pixel results and
// gain updates; a negedge monitor pops and compares whenever the DUT presents them.
module tb_awb_gain;
    import awb_gain_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    awb_gain_if bus ();

    awb_gain dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Gains become visible in the cycle that starts 29 edges after the sampling edge,
    // i.e. the 30th clock period counted from the one presenting mean_valid_i.
    localparam int LAT = 29;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct { int color; int value; } px_t;
    typedef struct { int at; int gr; int gb; } gn_t;
    px_t px_q[$];
    gn_t gn_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: one line per observed transaction.
    always @(negedge clk) begin : monitor
        px_t ep;
        gn_t eg;
        if (bus.valid_o) begin
            if (px_q.size() == 0) begin
                check("px_unexpected", 1, 0);
            end else begin
                ep = px_q.pop_front();
                $display("pixel  cyc=%0d color=%0d value=%0d expected=%0d",
                         cyc, bus.color_o, bus.value_o, ep.value);
                check("px_color", int'(bus.color_o), ep.color);
                check("px_value", int'(bus.value_o), ep.value);
            end
        end
        if (bus.gain_ready_o) begin
            if (gn_q.size() == 0) begin
                check("gain_ready_unexpected", 1, 0);
            end else begin
                eg = gn_q.pop_front();
                $display("gains  cyc=%0d gain_r=%0d gain_b=%0d expected cyc=%0d r=%0d b=%0d",
                         cyc, bus.gain_r_o, bus.gain_b_o, eg.at, eg.gr, eg.gb);
                check("gain_ready_cycle", cyc, eg.at);
                check("gain_r", int'(bus.gain_r_o), eg.gr);
                check("gain_b", int'(bus.gain_b_o), eg.gb);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present means for one cycle; t0 is the cycle index right after the sampling edge.
    task automatic send_means(input int r, input int g, input int b, output int t0);
        bus.mean_valid_i = 1'b1;
        bus.r_mean_i     = DATA_W'(r);
        bus.g_mean_i     = DATA_W'(g);
        bus.b_mean_i     = DATA_W'(b);
        tick();
        t0 = cyc;
        bus.mean_valid_i = 1'b0;
    endtask

    task automatic drive_px(input int color, input int value, input int exp);
        bus.valid_i = 1'b1;
        bus.color_i = 2'(color);
        bus.value_i = DATA_W'(value);
        px_q.push_back('{color, exp});
        tick();
        bus.valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy_o && n < 100) begin
            tick();
            n++;
        end
        check("wait_idle_timeout", int'(bus.busy_o), 0);
        repeat (2) tick();
    endtask

    int t0;

    initial begin
        bus.mean_valid_i = 1'b0;
        bus.r_mean_i     = '0;
        bus.g_mean_i     = '0;
        bus.b_mean_i     = '0;
        bus.valid_i      = 1'b0;
        bus.color_i      = '0;
        bus.value_i      = 8'd99;

        // Reset state
        repeat (3) tick();
        check("rst_valid_o", int'(bus.valid_o), 0);
        check("rst_color_o", int'(bus.color_o), 0);
        check("rst_value_o", int'(bus.value_o), 0);
        check("rst_gain_ready", int'(bus.gain_ready_o), 0);
        check("rst_busy", int'(bus.busy_o), 0);
        check("rst_gain_r", int'(bus.gain_r_o), 64);
        check("rst_gain_b", int'(bus.gain_b_o), 64);
        rst = 1'b0;
        tick();

        // 1: r=64 g=128 b=32 -> 8192/64=128, 8192/32=256
        send_means(64, 128, 32, t0);
        gn_q.push_back('{t0 + LAT, 128, 256});
        check("t1_busy", int'(bus.busy_o), 1);
        repeat (LAT - 1) tick();
        check("t1_gain_r_still_old", int'(bus.gain_r_o), 64);
        tick();
        check("t1_gain_r_new", int'(bus.gain_r_o), 128);
        check("t1_gain_b_new", int'(bus.gain_b_o), 256);
        wait_idle();
        drive_px(0, 100, 200);   // 100*128/64
        drive_px(2, 100, 255);   // 400 saturates
        drive_px(1, 100, 100);
        drive_px(3, 100, 100);
        repeat (2) tick();

        // 6: reset at cycle 10 of DIV_R discards the calculation
        send_means(32, 200, 100, t0);
        repeat (9) tick();
        check("t6_busy_before_rst", int'(bus.busy_o), 1);
        rst = 1'b1;
        tick();
        check("t6_busy_after_rst", int'(bus.busy_o), 0);
        check("t6_gain_r_after_rst", int'(bus.gain_r_o), 64);
        check("t6_gain_b_after_rst", int'(bus.gain_b_o), 64);
        rst = 1'b0;
        repeat (40) tick();      // any gain_ready_o here is flagged by the monitor

        // 3 (also the fresh start after reset): r=0 -> 1023, b=1 -> 16320 saturates to 1023
        send_means(0, 255, 1, t0);
        gn_q.push_back('{t0 + LAT, 1023, 1023});
        wait_idle();
        drive_px(0, 10, 159);    // 10*1023/64 = 159.8
        drive_px(2, 0, 0);
        drive_px(0, 200, 255);
        repeat (2) tick();

        // 4: second means 5 cycles later are ignored; 4096/128=32, 4096/255=16
        send_means(128, 64, 255, t0);
        gn_q.push_back('{t0 + LAT, 32, 16});
        repeat (4) tick();
        send_means(90, 90, 90, t0);
        wait_idle();
        repeat (40) tick();
        drive_px(0, 100, 50);
        drive_px(2, 100, 25);
        repeat (2) tick();

        // 5: R pixels straddling LOAD, plus means accepted the cycle after LOAD
        send_means(64, 128, 32, t0);
        gn_q.push_back('{t0 + LAT, 128, 256});
        repeat (LAT - 1) tick();
        drive_px(0, 100, 50);    // sampled on the LOAD edge: old gain 32
        bus.mean_valid_i = 1'b1;
        bus.r_mean_i     = 8'd90;
        bus.g_mean_i     = 8'd90;
        bus.b_mean_i     = 8'd90;
        drive_px(0, 100, 200);   // next edge: new gain 128
        bus.mean_valid_i = 1'b0;
        gn_q.push_back('{cyc + LAT, 64, 64});
        check("t5_accept_after_load", int'(bus.busy_o), 1);
        wait_idle();

        // 2: equal means give unity gains, pixels pass through
        drive_px(0, 0, 0);
        drive_px(1, 77, 77);
        drive_px(2, 255, 255);
        drive_px(0, 255, 255);
        drive_px(2, 77, 77);
        repeat (3) tick();

        check("px_queue_drained", px_q.size(), 0);
        check("gain_queue_drained", gn_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
